// File: rtl/neuron_mac_if.sv
// Stream bundle for neuron_mac: start/bias command, x/w input beats and the
// accumulated-sum result, each with its own valid/ready pair.
interface neuron_mac_if #(
  parameter int DATA_W = 8,
  parameter int PROD_W = 16,
  parameter int ACC_W  = 21
);
  logic                     start;
  logic signed [PROD_W-1:0] bias_in;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] w_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     busy;

  modport master (
    output start, bias_in, in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  start, bias_in, in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, out_sum, busy
  );
endinterface

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate for one MLP neuron: bias preload, N_TERMS
// signed byte products accumulated, result held until downstream accepts it.
module neuron_mac #(
  parameter int DATA_W  = 8,
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 21,
  parameter int N_TERMS = 30,
  parameter int CNT_W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  neuron_mac_if.slave    io
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cnt_next;

  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] w;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic                     beat;
  logic                     last_beat;

  assign x    = io.x_in;
  assign w    = io.w_in;
  assign prod = x * w;

  // Explicit replication keeps the sign extension independent of cast rules.
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-PROD_W){io.bias_in[PROD_W-1]}}, io.bias_in};

  assign beat      = io.in_valid && (state == ACC);
  assign last_beat = beat && (cnt == CNT_W'(N_TERMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (io.start) begin
          acc_next   = bias_ext;
          cnt_next   = '0;
          state_next = ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_next = acc + prod_ext;
          cnt_next = cnt + CNT_W'(1);
          if (last_beat) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every output is a decode of state or the accumulator register itself.
  assign io.in_ready  = (state == ACC);
  assign io.out_valid = (state == DONE);
  assign io.busy      = (state != IDLE);
  assign io.out_sum   = acc;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with N_TERMS = 4, 32 and 1 instances.
module tb_neuron_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_mac_if #(.DATA_W(8), .PROD_W(16), .ACC_W(21)) bus4 ();
  neuron_mac_if #(.DATA_W(8), .PROD_W(16), .ACC_W(21)) bus32 ();
  neuron_mac_if #(.DATA_W(8), .PROD_W(16), .ACC_W(21)) bus1 ();

  neuron_mac #(.DATA_W(8), .PROD_W(16), .ACC_W(21), .N_TERMS(4), .CNT_W(2))
    dut4 (.clk(clk), .rst_n(rst_n), .io(bus4));
  neuron_mac #(.DATA_W(8), .PROD_W(16), .ACC_W(21), .N_TERMS(32), .CNT_W(5))
    dut32 (.clk(clk), .rst_n(rst_n), .io(bus32));
  neuron_mac #(.DATA_W(8), .PROD_W(16), .ACC_W(21), .N_TERMS(1), .CNT_W(1))
    dut1 (.clk(clk), .rst_n(rst_n), .io(bus1));

  int checks = 0;
  int errors = 0;

  logic signed [7:0]  xs [4];
  logic signed [7:0]  ws [4];
  int                 lat;
  logic signed [31:0] model;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Call at a negedge; start is driven at once. Returns at the negedge where
  // out_valid is first seen, or early once abort_after beats were accepted.
  task automatic stream4(input logic signed [15:0] bias, input bit stall,
                         input int abort_after, output int lat_o,
                         output logic signed [31:0] model_o);
    int k = 0;
    int step = 0;
    bit acc_now;
    model_o = 32'(bias);
    bus4.start    = 1'b1;
    bus4.bias_in  = bias;
    bus4.x_in     = xs[0];
    bus4.w_in     = ws[0];
    bus4.in_valid = 1'b1;
    lat_o = 0;
    while (!bus4.out_valid && lat_o < 200) begin
      acc_now = bus4.in_valid && bus4.in_ready;
      @(negedge clk);
      lat_o++;
      bus4.start = 1'b0;
      if (acc_now) begin
        model_o += xs[k] * ws[k];
        k++;
      end
      if (k == abort_after) return;
      if (stall && bus4.busy && !bus4.out_valid)
        check("acc_track", dut4.acc, model_o);
      step++;
      if (k < 4) begin
        bus4.in_valid = stall ? (step % 3 == 0) : 1'b1;
        bus4.x_in     = bus4.in_valid ? xs[k] : 8'sh7F;
        bus4.w_in     = bus4.in_valid ? ws[k] : 8'sh7F;
      end else begin
        bus4.in_valid = 1'b0;
      end
    end
    bus4.in_valid = 1'b0;
  endtask

  initial begin
    bus4.start = 0;  bus4.bias_in = '0;  bus4.in_valid = 0;
    bus4.x_in = '0;  bus4.w_in = '0;     bus4.out_ready = 0;
    bus32.start = 0; bus32.bias_in = '0; bus32.in_valid = 0;
    bus32.x_in = '0; bus32.w_in = '0;    bus32.out_ready = 0;
    bus1.start = 0;  bus1.bias_in = '0;  bus1.in_valid = 0;
    bus1.x_in = '0;  bus1.w_in = '0;     bus1.out_ready = 0;
    xs = '{8'sd1, 8'sd3, -8'sd5, 8'sd7};
    ws = '{8'sd2, 8'sd4, 8'sd6, -8'sd8};

    // Reset state, with start/in_valid asserted to show they are ignored
    bus4.start = 1; bus4.in_valid = 1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus4.in_ready, 0);
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_busy", bus4.busy, 0);
    check("rst_out_sum", bus4.out_sum, 0);
    check("rst_busy32", bus32.busy, 0);
    bus4.start = 0; bus4.in_valid = 0;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: 10 + 2 + 12 - 30 - 56 = -62
    bus4.out_ready = 1;
    stream4(16'sd10, 1'b0, -1, lat, model);
    check("basic_valid", bus4.out_valid, 1);
    check("basic_sum", bus4.out_sum, -62);
    check("basic_latency", lat, 5);
    @(negedge clk);
    check("basic_one_cycle", bus4.out_valid, 0);
    check("basic_idle", bus4.busy, 0);

    // Stalled stream, started the cycle after the previous handshake
    stream4(16'sd10, 1'b1, -1, lat, model);
    check("stall_valid", bus4.out_valid, 1);
    check("stall_sum", bus4.out_sum, -62);
    @(negedge clk);
    check("stall_one_cycle", bus4.out_valid, 0);

    // Backpressure: -100 - 72 = -172 held while out_ready low
    bus4.out_ready = 0;
    stream4(-16'sd100, 1'b0, -1, lat, model);
    check("bp_valid", bus4.out_valid, 1);
    for (int i = 0; i < 7; i++) begin
      bus4.start    = (i == 2);
      bus4.bias_in  = 16'sd555;
      bus4.in_valid = (i == 2);
      @(negedge clk);
      check("bp_hold_valid", bus4.out_valid, 1);
      check("bp_hold_sum", bus4.out_sum, -172);
    end
    bus4.start = 0; bus4.in_valid = 0;
    bus4.out_ready = 1;
    @(negedge clk);
    check("bp_release_valid", bus4.out_valid, 0);
    check("bp_release_busy", bus4.busy, 0);

    // Abort mid-ACC after 2 beats
    stream4(16'sd50, 1'b0, 2, lat, model);
    check("abort_busy_before", bus4.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", bus4.in_ready, 0);
    check("abort_out_valid", bus4.out_valid, 0);
    check("abort_busy", bus4.busy, 0);
    check("abort_out_sum", bus4.out_sum, 0);
    bus4.in_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xs = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    ws = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    stream4(16'sd0, 1'b0, -1, lat, model);
    check("fresh_valid", bus4.out_valid, 1);
    check("fresh_sum", bus4.out_sum, 4);
    @(negedge clk);
    check("fresh_done", bus4.out_valid, 0);

    // Extremes, N_TERMS = 32: 32 * 16384 = 524288
    bus32.start = 1; bus32.bias_in = 16'sd0;
    bus32.x_in = -8'sd128; bus32.w_in = -8'sd128; bus32.in_valid = 1;
    @(negedge clk);
    bus32.start = 0;
    lat = 1;
    while (!bus32.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("ext_pos_valid", bus32.out_valid, 1);
    check("ext_pos_sum", bus32.out_sum, 524288);
    check("ext_latency", lat, 33);
    bus32.out_ready = 1;
    @(negedge clk);
    check("ext_pos_done", bus32.out_valid, 0);
    bus32.out_ready = 0;

    // 32 * (-16256) - 32768 = -552960
    bus32.start = 1; bus32.bias_in = 16'sh8000;
    bus32.x_in = -8'sd128; bus32.w_in = 8'sd127;
    @(negedge clk);
    bus32.start = 0;
    lat = 1;
    while (!bus32.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("ext_neg_valid", bus32.out_valid, 1);
    check("ext_neg_sum", bus32.out_sum, -552960);
    bus32.in_valid = 0;
    bus32.out_ready = 1;
    @(negedge clk);
    check("ext_neg_done", bus32.out_valid, 0);

    // N_TERMS = 1 with out_ready held high: 5 + 3 * -2 = -1
    bus1.out_ready = 1;
    bus1.start = 1; bus1.bias_in = 16'sd5;
    bus1.x_in = 8'sd3; bus1.w_in = -8'sd2; bus1.in_valid = 1;
    @(negedge clk);
    bus1.start = 0;
    check("n1_in_ready", bus1.in_ready, 1);
    @(negedge clk);
    check("n1_valid", bus1.out_valid, 1);
    check("n1_sum", bus1.out_sum, -1);
    @(negedge clk);
    check("n1_one_transfer", bus1.out_valid, 0);
    check("n1_idle", bus1.busy, 0);
    @(negedge clk);
    check("n1_stays_idle", bus1.busy, 0);
    bus1.in_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
